// File: rtl/uart_v2_rx_if.sv
// Consumer-side bundle of the oversampling UART receiver:
// received byte, status flags and the read strobe.
interface uart_v2_rx_if;
  logic [7:0] parallel_out;
  logic       data_ready;
  logic       framing_error;
  logic       overrun;
  logic       read_ack;

  modport master (
    output parallel_out,
    output data_ready,
    output framing_error,
    output overrun,
    input  read_ack
  );

  modport slave (
    input  parallel_out,
    input  data_ready,
    input  framing_error,
    input  overrun,
    output read_ack
  );
endinterface

// File: rtl/uart_v2_rx.sv
// 8N1 UART receiver, OVERSAMPLE ticks per bit, mid-bit sampling,
// sticky framing/overrun flags cleared by a one-tick read_ack.
module uart_v2_rx #(
  parameter int OVERSAMPLE = 4
) (
  input  logic          uart_sample_clk,
  input  logic          sysreset_n,
  input  logic          rx_line,
  output logic          rx_busy,
  uart_v2_rx_if.master  rd
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q, sync_d;
  logic [1:0]    vld_q, vld_d;
  logic          armed_q, armed_d;
  logic [7:0]    pout_q, pout_d;
  logic          dr_q, dr_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          rx_s;

  assign rx_s = sync_q[1];
  assign sync_d = {sync_q[0], rx_line};
  assign vld_d = {vld_q[0], 1'b1};
  // A start needs a genuine high sample first; the synchronizer's
  // reset ones do not count, so a frame cut by reset is ignored.
  assign armed_d = vld_q[1] & rx_s;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pout_d  = pout_q;
    dr_d    = dr_q;
    fe_d    = fe_q;
    ov_d    = ov_q;
    if (rd.read_ack) begin
      dr_d = 1'b0;
      fe_d = 1'b0;
      ov_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!rx_s && armed_q) state_d = START;
      end
      START: begin
        if (tick_q == HALF) begin
          tick_d = '0;
          bit_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_q == LAST) begin
          tick_d = '0;
          shift_d[bit_q] = rx_s;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick_q == LAST) begin
          tick_d = '0;
          if (rx_s) begin
            pout_d = shift_q;
            dr_d   = 1'b1;
            if (dr_q && !rd.read_ack) ov_d = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        tick_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uart_sample_clk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sync_q  <= 2'b11;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      pout_q  <= 8'h00;
      dr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      pout_q  <= pout_d;
      dr_q    <= dr_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign rx_busy          = (state_q != IDLE);
  assign rd.parallel_out  = pout_q;
  assign rd.data_ready    = dr_q;
  assign rd.framing_error = fe_q;
  assign rd.overrun       = ov_q;

endmodule
